mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between the instruction-fetch requester (driven by the program counter's o_imem_raddr) and the load/store data requester.
- Serialises transactions with one outstanding access at a time.
- Enforces data-over-fetch priority with a starvation bound.
- Produces the fetch-stall signal that feeds the PC's i_hold input.

---
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of mem_port_arbiter.
// slave: the arbiter's view. master: the requester/memory environment's view.
interface mem_port_arbiter_if;
  // Fetch requester
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_ack;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        o_pc_hold;
  // Load/store requester
  logic        i_d_req;
  logic [31:0] i_d_addr;
  logic        i_d_wen;
  logic [31:0] i_d_wdata;
  logic [3:0]  i_d_wmask;
  logic        o_d_ack;
  logic        o_d_rvalid;
  logic [31:0] o_d_rdata;
  // Memory
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  // Status
  logic        o_err;
  logic [31:0] o_perf_if_stall;
  logic [31:0] o_perf_d_grants;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_ack, o_if_rvalid, o_if_rdata, o_pc_hold,
    input  i_d_req, i_d_addr, i_d_wen, i_d_wdata, i_d_wmask,
    output o_d_ack, o_d_rvalid, o_d_rdata,
    output o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_err, o_perf_if_stall, o_perf_d_grants
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_ack, o_if_rvalid, o_if_rdata, o_pc_hold,
    output i_d_req, i_d_addr, i_d_wen, i_d_wdata, i_d_wmask,
    input  o_d_ack, o_d_rvalid, o_d_rdata,
    input  o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_err, o_perf_if_stall, o_perf_d_grants
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch
// and load/store, one outstanding access at a time, data-over-fetch priority
// with a bounded data streak, and a response timeout.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned DATA_MAX_CONSEC = 4,
  parameter int unsigned TIMEOUT         = 255,
  parameter logic [31:0] ERR_DATA        = 32'h00000013
) (
  input logic               i_clk,
  input logic               i_rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CONSEC_W = 4;
  localparam int unsigned TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_cmd_t;

  state_t              state_q, state_d;
  logic                owner_d_q, owner_d_d;   // 1 = load/store owns the access
  logic [CONSEC_W-1:0] consec_q, consec_d;
  logic [TO_W-1:0]     tmo_q, tmo_d;
  mem_cmd_t            cmd_q, cmd_d;

  logic        arb_en, data_win, starve;
  logic        if_ack, d_ack, rsp_done, timeout_hit;
  logic        if_rvalid, d_rvalid, pc_hold;
  logic [31:0] rsp_data;

  // Fetch is forced through once the data streak reaches its bound
  assign starve   = bus.i_if_req && (consec_q == CONSEC_W'(DATA_MAX_CONSEC));
  assign data_win = bus.i_d_req && !starve;

  // Next-state, arbitration and command latch
  always_comb begin
    state_d     = state_q;
    owner_d_d   = owner_d_q;
    consec_d    = consec_q;
    tmo_d       = tmo_q;
    cmd_d       = cmd_q;
    arb_en      = 1'b0;
    if_ack      = 1'b0;
    d_ack       = 1'b0;
    rsp_done    = 1'b0;
    timeout_hit = 1'b0;

    case (state_q)
      IDLE: arb_en = 1'b1;
      REQ: begin
        if (bus.i_mem_gnt) begin
          state_d = RSP;
          tmo_d   = '0;
        end
      end
      RSP: begin
        if (bus.i_mem_rvalid) begin
          rsp_done = 1'b1;
          arb_en   = 1'b1;
          state_d  = IDLE;
        end else if ((TIMEOUT != 0) && (tmo_q == TO_W'(TIMEOUT - 32'd1))) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb_en) begin
      if (data_win) begin
        d_ack     = 1'b1;
        state_d   = REQ;
        owner_d_d = 1'b1;
        cmd_d     = '{addr: bus.i_d_addr, wen: bus.i_d_wen,
                      wdata: bus.i_d_wdata, wmask: bus.i_d_wmask};
        if (!bus.i_if_req) begin
          consec_d = '0;
        end else if (consec_q != CONSEC_W'(DATA_MAX_CONSEC)) begin
          consec_d = consec_q + CONSEC_W'(1);
        end
      end else if (bus.i_if_req) begin
        if_ack    = 1'b1;
        state_d   = REQ;
        owner_d_d = 1'b0;
        consec_d  = '0;
        cmd_d     = '{addr: bus.i_if_addr, wen: 1'b0, wdata: 32'd0, wmask: 4'd0};
      end
    end
  end

  // State and command registers; reset abandons any in-flight access
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      owner_d_q <= 1'b0;
      consec_q  <= '0;
      tmo_q     <= '0;
      cmd_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_d_q <= owner_d_d;
      consec_q  <= consec_d;
      tmo_q     <= tmo_d;
      cmd_q     <= cmd_d;
    end
  end

  assign rsp_data  = timeout_hit ? ERR_DATA : bus.i_mem_rdata;
  assign if_rvalid = (rsp_done || timeout_hit) && !owner_d_q;
  assign d_rvalid  = (rsp_done || timeout_hit) && owner_d_q;
  assign pc_hold   = bus.i_if_req && !if_rvalid;

  assign bus.o_if_ack    = if_ack;
  assign bus.o_if_rvalid = if_rvalid;
  assign bus.o_if_rdata  = if_rvalid ? rsp_data : 32'd0;
  assign bus.o_pc_hold   = pc_hold;
  assign bus.o_d_ack     = d_ack;
  assign bus.o_d_rvalid  = d_rvalid;
  assign bus.o_d_rdata   = d_rvalid ? rsp_data : 32'd0;
  assign bus.o_mem_req   = (state_q == REQ);
  assign bus.o_mem_addr  = cmd_q.addr;
  assign bus.o_mem_wen   = cmd_q.wen;
  assign bus.o_mem_wdata = cmd_q.wdata;
  assign bus.o_mem_wmask = cmd_q.wmask;
  assign bus.o_err       = timeout_hit;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_dg_q;

  // Fetch stall cycles and data grants, wrapping modulo 2^32
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perf_stall_q <= 32'd0;
      perf_dg_q    <= 32'd0;
    end else begin
      if (pc_hold) perf_stall_q <= perf_stall_q + 32'd1;
      if (d_ack)   perf_dg_q    <= perf_dg_q + 32'd1;
    end
  end

  assign bus.o_perf_if_stall = perf_stall_q;
  assign bus.o_perf_d_grants = perf_dg_q;
`else
  assign bus.o_perf_if_stall = 32'd0;
  assign bus.o_perf_d_grants = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal expectations
// plus a transaction-level reference model compared on every falling edge.
module tb_mem_port_arbiter;

  localparam int unsigned MAXC = 4;
  localparam int unsigned TMO  = 8;
  localparam logic [31:0] ERRD = 32'h00000013;
  localparam logic [31:0] KEY  = 32'hDEADBFEF;  // memory returns addr ^ KEY

  logic clk;
  logic rst_n;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.DATA_MAX_CONSEC(MAXC), .TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_busy, m_granted, m_owner_d;
  int          m_wait, m_streak;
  logic [31:0] m_addr, m_wdata, m_stall, m_dg;
  logic        m_wen;
  logic [3:0]  m_wmask;

  always @(negedge clk) begin
    bit respond, tmo, done, arb, dsel, dwin, fwin, e_if_rv, e_d_rv, e_hold;
    logic [31:0] e_rd;
    if (!rst_n) begin
      m_busy = 0; m_granted = 0; m_owner_d = 0; m_wait = 0; m_streak = 0;
      m_addr = 0; m_wdata = 0; m_wen = 0; m_wmask = 0; m_stall = 0; m_dg = 0;
    end
    respond = m_busy && m_granted;
    tmo     = respond && !bus.i_mem_rvalid && (TMO != 0) && (m_wait == int'(TMO));
    done    = respond && (bus.i_mem_rvalid || tmo);
    arb     = !m_busy || (respond && bus.i_mem_rvalid);
    dsel    = bus.i_d_req && !(bus.i_if_req && m_streak == int'(MAXC));
    dwin    = arb && dsel;
    fwin    = arb && !dsel && bus.i_if_req;
    e_if_rv = done && !m_owner_d;
    e_d_rv  = done && m_owner_d;
    e_rd    = tmo ? ERRD : bus.i_mem_rdata;
    e_hold  = bus.i_if_req && !e_if_rv;

    chk("if_ack",    32'(bus.o_if_ack),    32'(fwin));
    chk("d_ack",     32'(bus.o_d_ack),     32'(dwin));
    chk("if_rvalid", 32'(bus.o_if_rvalid), 32'(e_if_rv));
    chk("d_rvalid",  32'(bus.o_d_rvalid),  32'(e_d_rv));
    if (e_if_rv) chk("if_rdata", bus.o_if_rdata, e_rd);
    if (e_d_rv && !m_wen) chk("d_rdata", bus.o_d_rdata, e_rd);
    chk("err",       32'(bus.o_err),       32'(tmo));
    chk("pc_hold",   32'(bus.o_pc_hold),   32'(e_hold));
    chk("mem_req",   32'(bus.o_mem_req),   32'(m_busy && !m_granted));
    chk("mem_addr",  bus.o_mem_addr,       m_addr);
    chk("mem_wen",   32'(bus.o_mem_wen),   32'(m_wen));
    chk("mem_wdata", bus.o_mem_wdata,      m_wdata);
    chk("mem_wmask", 32'(bus.o_mem_wmask), 32'(m_wmask));
`ifdef MEM_ARB_PERF_EN
    chk("perf_if_stall", bus.o_perf_if_stall, m_stall);
    chk("perf_d_grants", bus.o_perf_d_grants, m_dg);
`else
    chk("perf_if_stall", bus.o_perf_if_stall, 32'd0);
    chk("perf_d_grants", bus.o_perf_d_grants, 32'd0);
`endif

    if (rst_n) begin
      if (e_hold) m_stall = m_stall + 32'd1;
      if (dwin)   m_dg    = m_dg + 32'd1;
      if (dwin || fwin) begin
        m_busy = 1; m_granted = 0; m_owner_d = dwin;
        if (dwin) begin
          m_addr = bus.i_d_addr; m_wen = bus.i_d_wen;
          m_wdata = bus.i_d_wdata; m_wmask = bus.i_d_wmask;
          m_streak = bus.i_if_req ? ((m_streak < int'(MAXC)) ? m_streak + 1 : m_streak) : 0;
        end else begin
          m_addr = bus.i_if_addr; m_wen = 0; m_wdata = 0; m_wmask = 0;
          m_streak = 0;
        end
      end else if (done) begin
        m_busy = 0;
      end else if (m_busy && !m_granted) begin
        if (bus.i_mem_gnt) begin m_granted = 1; m_wait = 1; end
      end else if (respond) begin
        m_wait++;
      end
    end
  end

  // ---------------- stimulus environment ----------------
  bit s_ia, s_iv, s_da;
  always @(negedge clk) begin
    s_ia = bus.o_if_ack; s_iv = bus.o_if_rvalid; s_da = bus.o_d_ack;
  end

  bit          f_pend, f_out;
  logic [31:0] f_addr;
  int          d_cnt;
  logic [31:0] d_addr, d_wdata;
  logic        d_wen;
  logic [3:0]  d_wmask;
  int          r_gnt_lat = 0, r_rsp_lat = 1, r_req_age = 0, r_age = 0;
  bit          r_never = 0, r_wait = 0, r_stray = 0;
  logic [31:0] r_addr;

  task automatic drive_idle();
    bus.i_if_req = 0; bus.i_if_addr = 0; bus.i_d_req = 0; bus.i_d_addr = 0;
    bus.i_d_wen = 0; bus.i_d_wdata = 0; bus.i_d_wmask = 0;
    bus.i_mem_gnt = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = 0;
  endtask

  // One clock: update requesters/memory from last cycle's handshakes, drive, settle
  task automatic go();
    @(posedge clk); #1;
    if (s_iv) f_out = 0;
    if (s_ia) begin f_pend = 0; f_out = 1; end
    if (s_da) begin d_cnt--; d_addr = d_addr + 32'd4; end
    bus.i_mem_gnt = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = 0;
    if (r_wait) begin
      r_age++;
      if (!r_never && r_age == r_rsp_lat) begin
        bus.i_mem_rvalid = 1; bus.i_mem_rdata = r_addr ^ KEY; r_wait = 0;
      end
    end
    if (r_stray) begin bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'hBAD0BAD0; r_stray = 0; end
    if (bus.o_mem_req) begin
      if (r_req_age == r_gnt_lat) begin
        bus.i_mem_gnt = 1; r_wait = 1; r_age = 0; r_addr = bus.o_mem_addr; r_req_age = 0;
      end else r_req_age++;
    end else r_req_age = 0;
    bus.i_if_req  = f_pend || (f_out && !bus.i_mem_rvalid);
    bus.i_if_addr = f_addr;
    bus.i_d_req   = (d_cnt > 0);
    bus.i_d_addr  = d_addr; bus.i_d_wen = d_wen; bus.i_d_wdata = d_wdata; bus.i_d_wmask = d_wmask;
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_req"},  32'(bus.o_mem_req),   32'd0);
    chk({tag, "_mem_addr"}, bus.o_mem_addr,       32'd0);
    chk({tag, "_mem_wen"},  32'(bus.o_mem_wen),   32'd0);
    chk({tag, "_mem_wdat"}, bus.o_mem_wdata,      32'd0);
    chk({tag, "_mem_wmsk"}, 32'(bus.o_mem_wmask), 32'd0);
    chk({tag, "_if_ack"},   32'(bus.o_if_ack),    32'd0);
    chk({tag, "_if_rv"},    32'(bus.o_if_rvalid), 32'd0);
    chk({tag, "_d_ack"},    32'(bus.o_d_ack),     32'd0);
    chk({tag, "_d_rv"},     32'(bus.o_d_rvalid),  32'd0);
    chk({tag, "_err"},      32'(bus.o_err),       32'd0);
    chk({tag, "_hold"},     32'(bus.o_pc_hold),   32'd0);
    chk({tag, "_perf_st"},  bus.o_perf_if_stall,  32'd0);
    chk({tag, "_perf_dg"},  bus.o_perf_d_grants,  32'd0);
  endtask

  byte seq[$];

  initial begin
    rst_n = 0;
    f_pend = 0; f_out = 0; f_addr = 0;
    d_cnt = 0; d_addr = 0; d_wen = 0; d_wdata = 0; d_wmask = 0;
    drive_idle();
    repeat (2) @(posedge clk);
    #3 check_all_zero("rst");
    @(negedge clk); #2 rst_n = 1;
    repeat (2) go();

    // Fetch only: ack c0, memory request c1, data c2
    f_pend = 1; f_addr = 32'h100;
    go(); chk("f_c0_ack", 32'(bus.o_if_ack), 32'd1); chk("f_c0_hold", 32'(bus.o_pc_hold), 32'd1);
    go(); chk("f_c1_req", 32'(bus.o_mem_req), 32'd1); chk("f_c1_addr", bus.o_mem_addr, 32'h100);
          chk("f_c1_hold", 32'(bus.o_pc_hold), 32'd1);
    go(); chk("f_c2_rv", 32'(bus.o_if_rvalid), 32'd1); chk("f_c2_rdata", bus.o_if_rdata, 32'hDEADBEEF);
          chk("f_c2_hold", 32'(bus.o_pc_hold), 32'd0);
    repeat (2) go();

    // Simultaneous: data first, fetch acked in the data response cycle
    f_pend = 1; f_addr = 32'h200; d_cnt = 1; d_addr = 32'h8000; d_wen = 0;
    go(); chk("s_c0_dack", 32'(bus.o_d_ack), 32'd1); chk("s_c0_iack", 32'(bus.o_if_ack), 32'd0);
    go(); chk("s_c1_addr", bus.o_mem_addr, 32'h8000);
    go(); chk("s_c2_drv", 32'(bus.o_d_rvalid), 32'd1); chk("s_c2_drd", bus.o_d_rdata, 32'hDEAD3FEF);
          chk("s_c2_iack", 32'(bus.o_if_ack), 32'd1);
    go(); chk("s_c3_addr", bus.o_mem_addr, 32'h200);
    go(); chk("s_c4_irv", 32'(bus.o_if_rvalid), 32'd1); chk("s_c4_ird", bus.o_if_rdata, 32'hDEADBDEF);
    repeat (2) go();

    // Starvation bound: data held continuously while a fetch waits
    f_pend = 1; f_addr = 32'h300; d_cnt = 6; d_addr = 32'h9000;
    seq.delete();
    for (int c = 0; c < 20; c++) begin
      go();
      if (bus.o_d_ack)  seq.push_back("D");
      if (bus.o_if_ack) seq.push_back("F");
    end
    chk("starve_cnt", 32'(seq.size()), 32'd7);
    for (int i = 0; i < 6 && i < seq.size(); i++)
      chk($sformatf("starve_g%0d", i), 32'(seq[i]), (i == 4) ? 32'("F") : 32'("D"));
    repeat (2) go();

    // Store with grant delayed: command stable through all request cycles
    d_cnt = 1; d_addr = 32'hA000; d_wen = 1; d_wdata = 32'hA5A5A5A5; d_wmask = 4'b0011;
    r_gnt_lat = 3;
    go(); chk("st_ack", 32'(bus.o_d_ack), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      go();
      chk($sformatf("st_c%0d_req", c), 32'(bus.o_mem_req), 32'd1);
      chk($sformatf("st_c%0d_addr", c), bus.o_mem_addr, 32'hA000);
      chk($sformatf("st_c%0d_wen", c), 32'(bus.o_mem_wen), 32'd1);
      chk($sformatf("st_c%0d_wd", c), bus.o_mem_wdata, 32'hA5A5A5A5);
      chk($sformatf("st_c%0d_wm", c), 32'(bus.o_mem_wmask), 32'h3);
    end
    go(); chk("st_rv", 32'(bus.o_d_rvalid), 32'd1);
    r_gnt_lat = 0; d_wen = 0; d_wdata = 0; d_wmask = 0;
    repeat (2) go();

    // Timeout: grant at c1, no response, error 8 cycles later
    r_never = 1; f_pend = 1; f_addr = 32'h400;
    go(); chk("to_ack", 32'(bus.o_if_ack), 32'd1);
    for (int c = 1; c <= 8; c++) go();
    chk("to_c8_err", 32'(bus.o_err), 32'd0);
    go(); chk("to_c9_err", 32'(bus.o_err), 32'd1); chk("to_c9_rv", 32'(bus.o_if_rvalid), 32'd1);
          chk("to_c9_rd", bus.o_if_rdata, ERRD);
    r_never = 0; r_wait = 0;
    go(); r_stray = 1;
    go(); chk("to_stray_irv", 32'(bus.o_if_rvalid), 32'd0); chk("to_stray_drv", 32'(bus.o_d_rvalid), 32'd0);
          chk("to_stray_err", 32'(bus.o_err), 32'd0);
    repeat (2) go();

    // Async reset while waiting for the response; late response ignored
    r_rsp_lat = 3; f_pend = 1; f_addr = 32'h500;
    go(); chk("rs_ack", 32'(bus.o_if_ack), 32'd1);
    go(); go();
    rst_n = 0; f_pend = 0; f_out = 0; d_cnt = 0;
    bus.i_if_req = 0; bus.i_d_req = 0;
    #1 check_all_zero("arst");
    @(negedge clk); #2 rst_n = 1;
    go();
    go(); chk("rs_late_rvin", 32'(bus.i_mem_rvalid), 32'd1);
          chk("rs_late_irv", 32'(bus.o_if_rvalid), 32'd0); chk("rs_late_drv", 32'(bus.o_d_rvalid), 32'd0);
          chk("rs_late_req", 32'(bus.o_mem_req), 32'd0);
    r_rsp_lat = 1;
    repeat (3) go();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
